// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

   localparam int SS_WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ss_state_t;

   // Bit counter must be able to hold the value WIDTH itself.
   function automatic int ss_cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
// Latency: purely combinational.
// Backpressure: none; always valid.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial A - B; optional signed overflow via SERIAL_SUBTRACTOR_SIGNED_OVF_EN.
// Latency: WIDTH+1 cycles from accepted start to done pulse.
// Backpressure: start ignored while busy; done may chain directly into the next start.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = SS_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow
);

   localparam int CNT_W = ss_cnt_w(WIDTH);

   ss_state_t        state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] sr_a;
   logic [WIDTH-1:0] sr_b;
   logic [WIDTH-2:0] res;
   logic [WIDTH-1:0] res_full;
   logic             bin_q;
   logic             cell_d;
   logic             cell_bout;
   logic             last_bit;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;

   full_subtractor u_fs (
      .a    (sr_a[0]),
      .b    (sr_b[0]),
      .bin  (bin_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // Current bit enters from the MSB side; on the last bit this is the full result.
   assign res_full = {cell_d, res};
   assign last_bit = (count == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         sr_a     <= '0;
         sr_b     <= '0;
         res      <= '0;
         bin_q    <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sr_a  <= a;
                  sr_b  <= b;
                  bin_q <= 1'b0;
                  count <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sr_a  <= sr_a >> 1;
               sr_b  <= sr_b >> 1;
               res   <= res_full[WIDTH-1:1];
               bin_q <= cell_bout;
               count <= count + CNT_W'(1);
               if (last_bit) begin
                  diff_q   <= res_full;
                  borrow_q <= cell_bout;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (start) begin
                  sr_a  <= a;
                  sr_b  <= b;
                  bin_q <= 1'b0;
                  count <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
   logic ovf_q;

   // On the last bit the operand registers hold the original sign bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state == RUN && last_bit) begin
         ovf_q <= (sr_a[0] != sr_b[0]) && (cell_d != sr_a[0]);
      end
   end

   assign overflow = ovf_q;
`else
   assign overflow = 1'b0;
`endif

   assign busy   = (state == RUN);
   assign done   = (state == DONE);
   assign diff   = diff_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised bench for serial_subtractor at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic       start4, busy4, done4, borrow4, ovf4;
   logic [3:0] a4, b4, diff4;
   logic       start8, busy8, done8, borrow8, ovf8;
   logic [7:0] a8, b8, diff8;

   int n_pass = 0;
   int n_tot  = 0;

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .overflow(ovf4)
   );

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .overflow(ovf8)
   );

   // Reference model: plain integer arithmetic on the operands.
   function automatic int ref_diff(input int w, input int a, input int b);
      return (a - b) & ((1 << w) - 1);
   endfunction

   function automatic logic ref_borrow(input int a, input int b);
      return a < b;
   endfunction

   function automatic logic ref_ovf(input int w, input int a, input int b);
      int sa, sb, sd;
      sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
      sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
      sd = sa - sb;
      return OVF_EN && ((sd > (1 << (w - 1)) - 1) || (sd < -(1 << (w - 1))));
   endfunction

   // Issue one start pulse and wait (bounded) for done; operands are scrambled after acceptance.
   task automatic do_op(input int w, input int a, input int b, output int d, output logic bo,
                        output logic ov, output int lat, output int busy_cnt);
      @(negedge clk);
      if (w == 8) begin a8 = 8'(a); b8 = 8'(b); start8 = 1'b1; end
      else begin a4 = 4'(a); b4 = 4'(b); start4 = 1'b1; end
      @(negedge clk);
      start4 = 1'b0; start8 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 1; busy_cnt = 0;
      while (!((w == 8) ? done8 : done4) && lat < 60) begin
         if ((w == 8) ? busy8 : busy4) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      d  = (w == 8) ? int'(diff8) : int'(diff4);
      bo = (w == 8) ? borrow8 : borrow4;
      ov = (w == 8) ? ovf8 : ovf4;
   endtask

   task automatic test_reset();
      rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0;
      repeat (3) @(negedge clk);
      n_tot++;
      if ({busy4, done4, diff4, borrow4, ovf4} !== 8'h00)
         $display("FAIL reset_w4 got busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
                  busy4, done4, diff4, borrow4, ovf4);
      else n_pass++;
      n_tot++;
      if ({busy8, done8, diff8, borrow8, ovf8} !== 12'h000)
         $display("FAIL reset_w8 got busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
                  busy8, done8, diff8, borrow8, ovf8);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_directed();
      int va[6] = '{9, 2, 7, 10, 0, 8};
      int vb[6] = '{3, 5, 15, 10, 15, 1};
      int d, lat, bc;
      logic bo, ov;
      for (int i = 0; i < 6; i++) begin
         do_op(4, va[i], vb[i], d, bo, ov, lat, bc);
         n_tot++;
         if (lat != 5 || bc != 4)
            $display("FAIL timing_%0d got lat=%0d busy=%0d want lat=5 busy=4", i, lat, bc);
         else n_pass++;
         n_tot++;
         if (d != ref_diff(4, va[i], vb[i]) || bo !== ref_borrow(va[i], vb[i]) ||
             ov !== ref_ovf(4, va[i], vb[i]))
            $display("FAIL directed_%0d a=%0d b=%0d got diff=%h borrow=%b ovf=%b want diff=%h borrow=%b ovf=%b",
                     i, va[i], vb[i], d, bo, ov, ref_diff(4, va[i], vb[i]),
                     ref_borrow(va[i], vb[i]), ref_ovf(4, va[i], vb[i]));
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int a, b, d, lat, bc;
      logic bo, ov;
      for (int i = 0; i < 16; i++) begin
         a = int'($urandom_range(0, 15));
         b = int'($urandom_range(0, 15));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_op(4, a, b, d, bo, ov, lat, bc);
         n_tot++;
         if (lat != 5 || d != ref_diff(4, a, b) || bo !== ref_borrow(a, b) || ov !== ref_ovf(4, a, b))
            $display("FAIL random_%0d a=%0d b=%0d got lat=%0d diff=%h borrow=%b ovf=%b want lat=5 diff=%h borrow=%b ovf=%b",
                     i, a, b, lat, d, bo, ov, ref_diff(4, a, b), ref_borrow(a, b), ref_ovf(4, a, b));
         else n_pass++;
      end
   endtask

   task automatic test_ignore_busy();
      logic [3:0] prev, got_d;
      logic       got_b;
      int         dones;
      bit         hold_bad;
      prev = diff4; dones = 0; hold_bad = 0; got_d = '0; got_b = 1'b0;
      @(negedge clk);
      a4 = 4'd12; b4 = 4'd5; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (i == 1) begin a4 = 4'd1; b4 = 4'd14; start4 = 1'b1; end
         if (i == 2) start4 = 1'b0;
         if (done4) begin
            dones++; got_d = diff4; got_b = borrow4;
         end else if (dones == 0 && diff4 !== prev) begin
            hold_bad = 1'b1;
         end
         @(negedge clk);
      end
      n_tot++;
      if (dones != 1) $display("FAIL busy_done_count got %0d want 1", dones);
      else n_pass++;
      n_tot++;
      if (got_d !== 4'd7 || got_b !== 1'b0)
         $display("FAIL busy_ignore got diff=%h borrow=%b want diff=7 borrow=0", got_d, got_b);
      else n_pass++;
      n_tot++;
      if (hold_bad) $display("FAIL diff_hold got partial change want diff=%h held", prev);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int qa[$], qb[$];
      int lat, last, ndone, ea, eb;
      lat = 0; last = 0; ndone = 0;
      @(negedge clk);
      ea = int'($urandom_range(0, 15)); eb = int'($urandom_range(0, 15));
      a4 = 4'(ea); b4 = 4'(eb); start4 = 1'b1;
      qa.push_back(ea); qb.push_back(eb);
      while (ndone < 5 && lat < 100) begin
         @(negedge clk);
         lat++;
         if (done4) begin
            ea = qa.pop_front(); eb = qb.pop_front();
            n_tot++;
            if (lat - last != 5 || int'(diff4) != ref_diff(4, ea, eb) || borrow4 !== ref_borrow(ea, eb))
               $display("FAIL b2b_%0d gap=%0d diff=%h borrow=%b want gap=5 diff=%h borrow=%b",
                        ndone, lat - last, diff4, borrow4, ref_diff(4, ea, eb), ref_borrow(ea, eb));
            else n_pass++;
            last = lat;
            ndone++;
            if (ndone < 5) begin
               ea = int'($urandom_range(0, 15)); eb = int'($urandom_range(0, 15));
               a4 = 4'(ea); b4 = 4'(eb);
               qa.push_back(ea); qb.push_back(eb);
            end else begin
               start4 = 1'b0;
            end
         end
      end
      start4 = 1'b0;
      n_tot++;
      if (ndone != 5) $display("FAIL b2b_count got %0d want 5", ndone);
      else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      int d, lat, bc, dones;
      logic bo, ov;
      do_op(4, 9, 3, d, bo, ov, lat, bc);
      @(negedge clk);
      a4 = 4'd13; b4 = 4'd2; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_tot++;
      if ({busy4, done4, diff4, borrow4, ovf4} !== 8'h00)
         $display("FAIL mid_reset got busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
                  busy4, done4, diff4, borrow4, ovf4);
      else n_pass++;
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         if (done4 || busy4) dones++;
         @(negedge clk);
      end
      n_tot++;
      if (dones != 0) $display("FAIL mid_reset_quiet got %0d active cycles want 0", dones);
      else n_pass++;
      do_op(4, 11, 4, d, bo, ov, lat, bc);
      n_tot++;
      if (lat != 5 || d != 7 || bo !== 1'b0)
         $display("FAIL post_reset_op got lat=%0d diff=%h borrow=%b want lat=5 diff=7 borrow=0", lat, d, bo);
      else n_pass++;
   endtask

   task automatic test_width8();
      int a, b, d, lat, bc;
      logic bo, ov;
      do_op(8, 200, 55, d, bo, ov, lat, bc);
      n_tot++;
      if (lat != 9 || bc != 8 || d != 145 || bo !== 1'b0 || ov !== ref_ovf(8, 200, 55))
         $display("FAIL w8_200_55 got lat=%0d busy=%0d diff=%0d borrow=%b ovf=%b want lat=9 busy=8 diff=145 borrow=0 ovf=%b",
                  lat, bc, d, bo, ov, ref_ovf(8, 200, 55));
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         do_op(8, a, b, d, bo, ov, lat, bc);
         n_tot++;
         if (lat != 9 || d != ref_diff(8, a, b) || bo !== ref_borrow(a, b) || ov !== ref_ovf(8, a, b))
            $display("FAIL w8_random_%0d a=%0d b=%0d got lat=%0d diff=%0d borrow=%b ovf=%b want lat=9 diff=%0d borrow=%b ovf=%b",
                     i, a, b, lat, d, bo, ov, ref_diff(8, a, b), ref_borrow(a, b), ref_ovf(8, a, b));
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid_run();
      test_width8();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
